// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, opcodes, cache geometry, FSM state type and immediate decoders.
package ifetch_pkg;
    localparam int ADDR_WID       = 32;
    localparam int INST_WID       = 32;
    localparam int DATA_WID       = 32;
    localparam int ICACHE_SIZE    = 16;
    localparam int ICACHE_IDX_WID = 4;
    localparam int ICACHE_TAG_WID = ADDR_WID - ICACHE_IDX_WID - 2;
    localparam logic [6:0] OPCODE_B   = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL = 7'b1101111;
    typedef enum logic {IDLE, WAIT} state_t;
    function automatic logic [ADDR_WID-1:0] imm_j(input logic [INST_WID-1:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction
    function automatic logic [ADDR_WID-1:0] imm_b(input logic [INST_WID-1:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction
endpackage

// File: rtl/ifetch_icache.sv
// ifetch_icache: direct-mapped one-word-per-line instruction cache, combinational lookup, synchronous fill.
// Ports: clk, rst (async, active-high, clears valid bits); rd_addr -> hit/rd_data; wr_en/wr_addr/wr_data fill a line.
module ifetch_icache
    import ifetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WID-1:2]   rd_addr,
    output logic                  hit,
    output logic [INST_WID-1:0]   rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WID-1:2]   wr_addr,
    input  logic [INST_WID-1:0]   wr_data
);
    logic [INST_WID-1:0]       data_q [ICACHE_SIZE];
    logic [ICACHE_TAG_WID-1:0] tag_q  [ICACHE_SIZE];
    logic [ICACHE_SIZE-1:0]    valid_q, valid_d;
    logic [ICACHE_IDX_WID-1:0] rd_idx, wr_idx;
    assign rd_idx  = rd_addr[ICACHE_IDX_WID+1:2];
    assign wr_idx  = wr_addr[ICACHE_IDX_WID+1:2];
    assign rd_data = data_q[rd_idx];
    assign hit     = valid_q[rd_idx] && tag_q[rd_idx] == rd_addr[ADDR_WID-1:ICACHE_IDX_WID+2];
    always_comb begin
        valid_d = valid_q;
        if (wr_en) valid_d[wr_idx] = 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end
    // Data and tag are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx] <= wr_data;
            tag_q[wr_idx]  <= wr_addr[ADDR_WID-1:ICACHE_IDX_WID+2];
        end
    end
endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit with I-cache, miss FSM (IDLE/WAIT) and optional BHT predictor.
// Ports: clk, rst (async, active-high), rdy, stall, rollback/rollback_pc, br_upd*, mc_* memory port,
// inst_done/inst/inst_pc/inst_pre_j decoder port. Macro BRANCH_PREDICT_EN enables the 2-bit BHT.
module ifetch
    import ifetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 stall,
    input  logic                 rollback,
    input  logic [ADDR_WID-1:0]  rollback_pc,
    input  logic                 br_upd,
    input  logic [ADDR_WID-1:0]  br_upd_pc,
    input  logic                 br_upd_taken,
    output logic                 mc_en,
    output logic [ADDR_WID-1:0]  mc_pc,
    input  logic                 mc_done,
    input  logic [DATA_WID-1:0]  mc_data,
    output logic                 inst_done,
    output logic [INST_WID-1:0]  inst,
    output logic [ADDR_WID-1:0]  inst_pc,
    output logic                 inst_pre_j
);
    state_t              state_q, state_d;
    logic [ADDR_WID-1:0] pc_q, pc_d, mc_pc_q, mc_pc_d, inst_pc_q, inst_pc_d, next_pc;
    logic [INST_WID-1:0] inst_q, inst_d, line;
    logic                mc_en_q, mc_en_d, inst_done_q, inst_done_d, inst_pre_j_q, inst_pre_j_d;
    logic                hit, pred, fill;
    // A fill lands even alongside rollback: the data is correct for its own address.
    assign fill = rdy && state_q == WAIT && mc_done;
    ifetch_icache u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (pc_q[ADDR_WID-1:2]),
        .hit     (hit),
        .rd_data (line),
        .wr_en   (fill),
        .wr_addr (mc_pc_q[ADDR_WID-1:2]),
        .wr_data (mc_data)
    );
`ifdef BRANCH_PREDICT_EN
    logic [1:0]                bht_q [ICACHE_SIZE];
    logic [1:0]                bht_d [ICACHE_SIZE];
    logic [ICACHE_IDX_WID-1:0] upd_idx;
    logic                      is_jal, is_b, unused_upd_pc;
    assign upd_idx       = br_upd_pc[ICACHE_IDX_WID+1:2];
    assign unused_upd_pc = ^{br_upd_pc[ADDR_WID-1:ICACHE_IDX_WID+2], br_upd_pc[1:0]};
    assign is_jal        = line[6:0] == OPCODE_JAL;
    assign is_b          = line[6:0] == OPCODE_B;
    assign pred          = is_jal || (is_b && bht_q[pc_q[ICACHE_IDX_WID+1:2]][1]);
    assign next_pc       = pc_q + (is_jal ? imm_j(line) : pred ? imm_b(line) : ADDR_WID'(4));
    always_comb begin
        bht_d = bht_q;
        if (rdy && br_upd)
            bht_d[upd_idx] = br_upd_taken ? (bht_q[upd_idx] == 2'd3 ? 2'd3 : bht_q[upd_idx] + 2'd1)
                                          : (bht_q[upd_idx] == 2'd0 ? 2'd0 : bht_q[upd_idx] - 2'd1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) for (int i = 0; i < ICACHE_SIZE; i++) bht_q[i] <= 2'b01;
        else     bht_q <= bht_d;
    end
`else
    logic unused_br;
    assign unused_br = ^{br_upd, br_upd_pc, br_upd_taken};
    assign pred      = 1'b0;
    assign next_pc   = pc_q + ADDR_WID'(4);
`endif
    always_comb begin
        pc_d         = pc_q;
        state_d      = state_q;
        mc_en_d      = mc_en_q;
        mc_pc_d      = mc_pc_q;
        inst_done_d  = 1'b0;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_pre_j_d = inst_pre_j_q;
        // While rdy is low a pending strobe is kept (but masked) so it is seen once rdy returns.
        if (!rdy) inst_done_d = inst_done_q;
        else if (rollback) begin
            pc_d    = rollback_pc;
            mc_en_d = 1'b0;
            state_d = IDLE;
        end else if (state_q == WAIT) begin
            mc_en_d = mc_done ? 1'b0 : mc_en_q;
            state_d = mc_done ? IDLE : WAIT;
        end else if (!stall && hit) begin
            inst_done_d  = 1'b1;
            inst_d       = line;
            inst_pc_d    = pc_q;
            inst_pre_j_d = pred;
            pc_d         = next_pc;
        end else if (!stall) begin
            mc_en_d = 1'b1;
            mc_pc_d = {pc_q[ADDR_WID-1:2], 2'b00};
            state_d = WAIT;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= '0;
            state_q      <= IDLE;
            mc_en_q      <= 1'b0;
            mc_pc_q      <= '0;
            inst_done_q  <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_pre_j_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            state_q      <= state_d;
            mc_en_q      <= mc_en_d;
            mc_pc_q      <= mc_pc_d;
            inst_done_q  <= inst_done_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_pre_j_q <= inst_pre_j_d;
        end
    end
    assign mc_en      = mc_en_q;
    assign mc_pc      = mc_pc_q;
    assign inst_done  = inst_done_q && rdy;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_pre_j = inst_pre_j_q;
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch (default or BRANCH_PREDICT_EN build).
module tb_ifetch;
    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, stall = 1'b0, rollback = 1'b0;
    logic [31:0] rollback_pc = '0, br_upd_pc = '0, mc_data = '0;
    logic        br_upd = 1'b0, br_upd_taken = 1'b0, mc_done = 1'b0;
    logic        mc_en, inst_done, inst_pre_j;
    logic [31:0] mc_pc, inst, inst_pc;
    logic [31:0] mem [64];
    int          errors = 0, checks = 0;
`ifdef BRANCH_PREDICT_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    ifetch dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .rollback(rollback), .rollback_pc(rollback_pc),
        .br_upd(br_upd), .br_upd_pc(br_upd_pc), .br_upd_taken(br_upd_taken),
        .mc_en(mc_en), .mc_pc(mc_pc), .mc_done(mc_done), .mc_data(mc_data),
        .inst_done(inst_done), .inst(inst), .inst_pc(inst_pc), .inst_pre_j(inst_pre_j)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL reset_mc_en: got %b want 0", mc_en); end
        checks++; if (mc_pc !== 32'h0) begin errors++; $display("FAIL reset_mc_pc: got %h want 0", mc_pc); end
        checks++; if (inst_done !== 1'b0) begin errors++; $display("FAIL reset_inst_done: got %b want 0", inst_done); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
        checks++; if (inst_pre_j !== 1'b0) begin errors++; $display("FAIL reset_pre_j: got %b want 0", inst_pre_j); end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        tick();
        checks++; if (mc_en !== 1'b1 || mc_pc !== 32'h0) begin errors++; $display("FAIL first_req: got en=%b pc=%h want en=1 pc=0", mc_en, mc_pc); end
        checks++; if (inst_done !== 1'b0) begin errors++; $display("FAIL first_no_done: got %b want 0", inst_done); end
        mc_done = 1'b1;
        mc_data = mem[0];
        tick();
        mc_done = 1'b0;
        checks++; if (mc_en !== 1'b0 || inst_done !== 1'b0) begin errors++; $display("FAIL first_fill: got en=%b done=%b want 0 0", mc_en, inst_done); end
        tick();
        checks++; if (inst_done !== 1'b1 || inst !== 32'h00500093 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL first_issue: got done=%b inst=%h pc=%h want 1 00500093 0", inst_done, inst, inst_pc); end
        stall = 1'b1;
        tick();
        checks++; if (inst_done !== 1'b0 || mc_en !== 1'b0) begin errors++; $display("FAIL first_single: got done=%b en=%b want 0 0", inst_done, mc_en); end
    endtask

    task automatic test_rollback_refetch();
        rollback = 1'b1;
        rollback_pc = 32'h0;
        stall = 1'b0;
        tick();
        rollback = 1'b0;
        checks++; if (inst_done !== 1'b0 || mc_en !== 1'b0) begin errors++; $display("FAIL rb_cycle: got done=%b en=%b want 0 0", inst_done, mc_en); end
        tick();
        checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h0 || mc_en !== 1'b0) begin
            errors++; $display("FAIL rb_refetch: got done=%b pc=%h en=%b want 1 0 0", inst_done, inst_pc, mc_en); end
        stall = 1'b1;
    endtask

    task automatic test_miss_stream();
        stall = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tick();
            checks++; if (mc_en !== 1'b1 || mc_pc !== 32'(4 * k)) begin
                errors++; $display("FAIL miss_req[%0d]: got en=%b pc=%h want 1 %h", k, mc_en, mc_pc, 32'(4 * k)); end
            mc_done = 1'b1;
            mc_data = mem[k];
            tick();
            mc_done = 1'b0;
            tick();
            checks++; if (inst_done !== 1'b1 || inst_pc !== 32'(4 * k) || inst !== mem[k]) begin
                errors++; $display("FAIL miss_issue[%0d]: got done=%b pc=%h inst=%h want 1 %h %h", k, inst_done, inst_pc, inst, 32'(4 * k), mem[k]); end
        end
        stall = 1'b1;
    endtask

    task automatic test_stall();
        rollback = 1'b1;
        rollback_pc = 32'h4;
        stall = 1'b0;
        tick();
        rollback = 1'b0;
        tick();
        checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h4) begin errors++; $display("FAIL hit_4: got done=%b pc=%h want 1 4", inst_done, inst_pc); end
        tick();
        checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h8) begin errors++; $display("FAIL hit_8: got done=%b pc=%h want 1 8", inst_done, inst_pc); end
        stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (inst_done !== 1'b0 || inst_pc !== 32'h8 || inst !== mem[2] || mc_en !== 1'b0) begin
                errors++; $display("FAIL stall[%0d]: got done=%b pc=%h inst=%h en=%b want 0 8 %h 0", c, inst_done, inst_pc, inst, mc_en, mem[2]); end
        end
        stall = 1'b0;
        tick();
        checks++; if (inst_done !== 1'b1 || inst_pc !== 32'hC) begin errors++; $display("FAIL resume_c: got done=%b pc=%h want 1 c", inst_done, inst_pc); end
        tick();
        checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h10) begin errors++; $display("FAIL resume_10: got done=%b pc=%h want 1 10", inst_done, inst_pc); end
        stall = 1'b1;
    endtask

    task automatic test_rollback_wait();
        rollback = 1'b1;
        rollback_pc = 32'h20;
        stall = 1'b0;
        tick();
        rollback = 1'b0;
        tick();
        checks++; if (mc_en !== 1'b1 || mc_pc !== 32'h20) begin errors++; $display("FAIL rbw_req: got en=%b pc=%h want 1 20", mc_en, mc_pc); end
        mc_done = 1'b1;
        mc_data = mem[8];
        rollback = 1'b1;
        rollback_pc = 32'h100;
        tick();
        mc_done = 1'b0;
        rollback = 1'b0;
        checks++; if (mc_en !== 1'b0 || inst_done !== 1'b0) begin errors++; $display("FAIL rbw_drop: got en=%b done=%b want 0 0", mc_en, inst_done); end
        tick();
        checks++; if (mc_en !== 1'b1 || mc_pc !== 32'h100) begin errors++; $display("FAIL rbw_next: got en=%b pc=%h want 1 100", mc_en, mc_pc); end
        rollback = 1'b1;
        rollback_pc = 32'h20;
        tick();
        rollback = 1'b0;
        checks++; if (mc_en !== 1'b0) begin errors++; $display("FAIL rbw_abort: got en=%b want 0", mc_en); end
        tick();
        checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h20 || inst !== 32'h00000863 || inst_pre_j !== 1'b0 || mc_en !== 1'b0) begin
            errors++; $display("FAIL rbw_line: got done=%b pc=%h inst=%h pj=%b en=%b want 1 20 00000863 0 0", inst_done, inst_pc, inst, inst_pre_j, mc_en); end
        tick();
        checks++; if (mc_en !== 1'b1 || mc_pc !== 32'h24) begin errors++; $display("FAIL rbw_nt_next: got en=%b pc=%h want 1 24", mc_en, mc_pc); end
        rollback = 1'b1;
        rollback_pc = 32'h20;
        stall = 1'b1;
        tick();
        rollback = 1'b0;
    endtask

    task automatic test_branch_predict();
        logic [31:0] exp_pc;
        exp_pc = BP ? 32'h30 : 32'h24;
        br_upd = 1'b1;
        br_upd_pc = 32'h20;
        br_upd_taken = 1'b1;
        tick();
        tick();
        br_upd = 1'b0;
        rollback = 1'b1;
        rollback_pc = 32'h20;
        stall = 1'b0;
        tick();
        rollback = 1'b0;
        tick();
        checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h20 || inst_pre_j !== BP) begin
            errors++; $display("FAIL bp_issue: got done=%b pc=%h pj=%b want 1 20 %b", inst_done, inst_pc, inst_pre_j, BP); end
        tick();
        checks++; if (mc_en !== 1'b1 || mc_pc !== exp_pc) begin errors++; $display("FAIL bp_target_req: got en=%b pc=%h want 1 %h", mc_en, mc_pc, exp_pc); end
        mc_done = 1'b1;
        mc_data = mem[exp_pc[7:2]];
        tick();
        mc_done = 1'b0;
        tick();
        checks++; if (inst_done !== 1'b1 || inst_pc !== exp_pc || inst_pre_j !== 1'b0) begin
            errors++; $display("FAIL bp_next_pc: got done=%b pc=%h pj=%b want 1 %h 0", inst_done, inst_pc, inst_pre_j, exp_pc); end
        stall = 1'b1;
    endtask

    task automatic test_wrap_and_rdy();
        rollback = 1'b1;
        rollback_pc = 32'hFFFFFFFC;
        stall = 1'b0;
        tick();
        rollback = 1'b0;
        tick();
        checks++; if (mc_en !== 1'b1 || mc_pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_req: got en=%b pc=%h want 1 fffffffc", mc_en, mc_pc); end
        mc_done = 1'b1;
        mc_data = mem[63];
        tick();
        mc_done = 1'b0;
        tick();
        checks++; if (inst_done !== 1'b1 || inst_pc !== 32'hFFFFFFFC || inst !== mem[63]) begin
            errors++; $display("FAIL wrap_issue: got done=%b pc=%h inst=%h want 1 fffffffc %h", inst_done, inst_pc, inst, mem[63]); end
        tick();
        checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h00500093) begin
            errors++; $display("FAIL wrap_next: got done=%b pc=%h inst=%h want 1 0 00500093", inst_done, inst_pc, inst); end
        rdy = 1'b0;
        #1;
        checks++; if (inst_done !== 1'b0) begin errors++; $display("FAIL rdy_mask: got %b want 0", inst_done); end
        tick();
        tick();
        checks++; if (inst_done !== 1'b0 || inst_pc !== 32'h0 || mc_en !== 1'b0) begin
            errors++; $display("FAIL rdy_hold: got done=%b pc=%h en=%b want 0 0 0", inst_done, inst_pc, mc_en); end
        rdy = 1'b1;
        tick();
        checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h4) begin errors++; $display("FAIL rdy_resume: got done=%b pc=%h want 1 4", inst_done, inst_pc); end
        stall = 1'b1;
    endtask

    task automatic test_async_reset();
        rollback = 1'b1;
        rollback_pc = 32'h40;
        stall = 1'b0;
        tick();
        rollback = 1'b0;
        tick();
        checks++; if (mc_en !== 1'b1 || mc_pc !== 32'h40) begin errors++; $display("FAIL ar_req: got en=%b pc=%h want 1 40", mc_en, mc_pc); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mc_en !== 1'b0 || mc_pc !== 32'h0) begin errors++; $display("FAIL ar_drop: got en=%b pc=%h want 0 0", mc_en, mc_pc); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (mc_en !== 1'b1 || mc_pc !== 32'h0 || inst_done !== 1'b0) begin
            errors++; $display("FAIL ar_cold: got en=%b pc=%h done=%b want 1 0 0", mc_en, mc_pc, inst_done); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h00000013 | (32'(i) << 20);
        mem[0] = 32'h00500093;
        mem[8] = 32'h00000863;
        test_reset();
        test_first_fetch();
        test_rollback_refetch();
        test_miss_stream();
        test_stall();
        test_rollback_wait();
        test_branch_predict();
        test_wrap_and_rdy();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
